// File: rtl/disp_share_arb_pkg.sv
// Shared constants for the display-sharing arbiter and its helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package disp_pkg;

   // Arbiter ownership states, 2-bit binary encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   // Decimal points are active-low at the segment driver, so all-ones blanks them.
   localparam logic [3:0]  DP_OFF   = 4'b1111;

   // Digit pattern shown while nobody owns the display.
   localparam logic [15:0] IDLE_HEX = 16'h0000;

endpackage

// File: rtl/disp_share_arb_if.sv
// Bundle of requester inputs and display-mux outputs around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; requests are levels, grants are the only feedback.
interface disp_share_arb_if;
   logic        req0;
   logic [15:0] val0;
   logic [3:0]  dp0;
   logic        req1;
   logic [15:0] val1;
   logic [3:0]  dp1;
   logic        gnt0;
   logic        gnt1;
   logic [3:0]  hex3;
   logic [3:0]  hex2;
   logic [3:0]  hex1;
   logic [3:0]  hex0;
   logic [3:0]  dp_out;
   logic        idle;

   // Requester / display side: drives requests and content, observes grants.
   modport master (
      output req0, val0, dp0, req1, val1, dp1,
      input  gnt0, gnt1, hex3, hex2, hex1, hex0, dp_out, idle
   );

   // Arbiter side.
   modport slave (
      input  req0, val0, dp0, req1, val1, dp1,
      output gnt0, gnt1, hex3, hex2, hex1, hex0, dp_out, idle
   );
endinterface

// File: rtl/disp_share_arb_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Latency: tick is high during the cycle the count sits at TICK_DIV-1.
// Backpressure: none; runs continuously regardless of consumers.
module tick_gen #(
   parameter int TICK_DIV = 50000,
   parameter int CW       = 16
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   // Count 0..TICK_DIV-1 and wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/disp_share_arb.sv
// Time-shares the 4-digit display mux between two requesters with a minimum hold.
// Latency: grants and content are registered, 1 cycle after the sampled request/content.
// Backpressure: none; a loser simply waits, release by the owner is immediate.
module disp_share_arb
   import disp_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int HOLD_TICKS = 1000,
   parameter int CW         = 16,
   parameter int HW         = 10
) (
   input  logic            clk,
   input  logic            reset,
   disp_share_arb_if.slave io_disp
);

   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [HW-1:0] r_hold;
   logic          r_last;      // last-served requester index
   logic          r_gnt0;
   logic          r_gnt1;
   logic          r_idle;
   logic [15:0]   r_hex;
   logic [3:0]    r_dp;
   logic          w_tick;
   logic          w_hold_done;
   logic          w_owning;

   tick_gen #(
      .TICK_DIV (TICK_DIV),
      .CW       (CW)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   assign w_hold_done = (r_hold == HOLD_MAX);
   assign w_owning    = (r_state == ST_OWN0) || (r_state == ST_OWN1);

   // Next-state choice: release is immediate, preemption only once hold has expired.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (io_disp.req0 && (!io_disp.req1 || r_last)) begin
               w_state_nxt = ST_OWN0;
            end else if (io_disp.req1) begin
               w_state_nxt = ST_OWN1;
            end
         end
         ST_OWN0: begin
            if (!io_disp.req0) begin
               w_state_nxt = io_disp.req1 ? ST_OWN1 : ST_IDLE;
            end else if (w_hold_done && io_disp.req1) begin
               w_state_nxt = ST_OWN1;
            end
         end
         ST_OWN1: begin
            if (!io_disp.req1) begin
               w_state_nxt = io_disp.req0 ? ST_OWN0 : ST_IDLE;
            end else if (w_hold_done && io_disp.req0) begin
               w_state_nxt = ST_OWN0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, hold counter, fairness pointer and outputs all follow the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
         r_last  <= 1'b1;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_idle  <= 1'b1;
         r_hex   <= IDLE_HEX;
         r_dp    <= DP_OFF;
      end else begin
         r_state <= w_state_nxt;

         // Entry cycle clears the count, so a coincident tick is dropped.
         if (w_state_nxt != r_state) begin
            r_hold <= '0;
         end else if (w_owning && w_tick && !w_hold_done) begin
            r_hold <= r_hold + 1'b1;
         end

         case (w_state_nxt)
            ST_OWN0: begin
               r_gnt0 <= 1'b1;
               r_gnt1 <= 1'b0;
               r_idle <= 1'b0;
               r_hex  <= io_disp.val0;
               r_dp   <= io_disp.dp0;
               if (r_state != ST_OWN0) begin
                  r_last <= 1'b0;
               end
            end
            ST_OWN1: begin
               r_gnt0 <= 1'b0;
               r_gnt1 <= 1'b1;
               r_idle <= 1'b0;
               r_hex  <= io_disp.val1;
               r_dp   <= io_disp.dp1;
               if (r_state != ST_OWN1) begin
                  r_last <= 1'b1;
               end
            end
            default: begin
               r_gnt0 <= 1'b0;
               r_gnt1 <= 1'b0;
               r_idle <= 1'b1;
               r_hex  <= IDLE_HEX;
               r_dp   <= DP_OFF;
            end
         endcase
      end
   end

   assign io_disp.gnt0   = r_gnt0;
   assign io_disp.gnt1   = r_gnt1;
   assign io_disp.idle   = r_idle;
   assign io_disp.hex3   = r_hex[15:12];
   assign io_disp.hex2   = r_hex[11:8];
   assign io_disp.hex1   = r_hex[7:4];
   assign io_disp.hex0   = r_hex[3:0];
   assign io_disp.dp_out = r_dp;

endmodule
